seg7_reader: RTL
================

Name: seg7_reader

Overview:
Reverse direction of our switch-to-HEX display path: decodes a 7-segment pattern set on the switches back into a hex nibble. On each KEY[0] press it captures the decoded digit into a 4-deep history and redisplays the history on HEX3..HEX0. Top-level lab block for the DE10-Lite board, pin-named like the other lab tops.

Parameters:
DEPTH, 4, number of history slots; fixed at 4 for this board's HEX0..HEX3 wiring.

Ports:
KEY[0]  input  1  clock; rising edge of the pushbutton
KEY[1]  input  1  reset; asynchronous, active-low
SW[6:0]  input  7  segment pattern under test, active-low, bit0=a .. bit6=g (same encoding we drive onto HEX)
SW[8]  input  1  synchronous clear of history, count and error
SW[9]  input  1  capture enable
LEDR[3:0]  output  4  last successfully decoded nibble
LEDR[7:5]  output  3  number of valid digits held, 0..4
LEDR[8]  output  1  sticky decode-error flag
LEDR[9]  output  1  last capture attempt was valid
HEX0  output  7  newest captured digit, active-low
HEX1..HEX3  output  7 each  older digits; HEX3 oldest

Behaviour:
- Reset (KEY[1]=0, asynchronous, any time including mid-press): all history slots = BLANK (1111111); HEX0..HEX3 = 1111111; LEDR all 0.
- Decode table (gfedcba, active-low), the only valid codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. All other codes, including BLANK 1111111, are invalid.
- Decode is combinational on SW[6:0]; all state updates on the rising edge of KEY[0]. One edge = one capture; no auto-repeat.
- Edge with SW[8]=1: clear wins over capture. History = BLANK, count=0, LEDR[8]=0, LEDR[9]=0, LEDR[3:0]=0.
- Edge with SW[8]=0, SW[9]=1, valid code: shift history (slot3<=slot2, slot2<=slot1, slot1<=slot0, slot0<=nibble); LEDR[3:0]<=nibble; LEDR[9]<=1; count<=min(count+1,4); the oldest digit is discarded once full.
- Edge with SW[8]=0, SW[9]=1, invalid code: history, count and LEDR[3:0] unchanged; LEDR[9]<=0; LEDR[8]<=1, sticky until clear or reset.
- Edge with SW[8]=0, SW[9]=0: no state change.
- HEXn output: a slot index < count drives the re-encoded nibble using the same table. Any other slot drives BLANK. HEX outputs are registered-state driven, with no combinational path from SW to HEX.
- Latency: captured digit appears on HEX0/LEDR one edge after the press (same edge that samples SW).

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111
  - the 16 digit pattern constants
  - the function seg7_encode(nibble) -> pattern
  - the function seg7_decode(pattern) -> {valid, nibble}
- One natural sub-module: seg7_enc (nibble + enable -> HEX pattern, BLANK when disabled), instantiated four times.

Test Plan:
- Reset then idle: KEY[1]=0 -> HEX0..3=1111111, LEDR=0; release, no press -> unchanged.
- Capture 1111001 with SW[9]=1, one press -> LEDR[3:0]=1, LEDR[9]=1, LEDR[7:5]=1, HEX0=1111001, HEX1..3 blank.
- Capture 2,3,4,5 in sequence -> count saturates at 4; HEX3..HEX0 show 3,4,5 and ... concretely after presses 1,2,3,4,5: HEX3=2 (0100100), HEX2=3, HEX1=4, HEX0=5 (0010010).
- Invalid 1111111 press after valid 'A' -> LEDR[8]=1, LEDR[9]=0, LEDR[3:0]=4'hA, HEX unchanged. A following valid 'C' press -> LEDR[9]=1, LEDR[8] stays 1.
- SW[8]=1 and SW[9]=1 with valid 'F' on the same press -> clear wins: all HEX blank, count 0, LEDR[8]=0.
- Assert KEY[1]=0 while KEY[0] is held high after a capture -> immediate blank and LEDR=0 without a clock edge. Next press after release captures normally.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit patterns (gfedcba, active-low),
// history depth and the encode/decode helpers used by the reader.
package seg7_pkg;

    localparam int DEPTH = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Nibble -> segment pattern.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    // Segment pattern -> {valid, nibble}; anything off-table is invalid.
    function automatic logic [4:0] seg7_decode(input logic [6:0] pattern);
        case (pattern)
            SEG_0:   return {1'b1, 4'h0};
            SEG_1:   return {1'b1, 4'h1};
            SEG_2:   return {1'b1, 4'h2};
            SEG_3:   return {1'b1, 4'h3};
            SEG_4:   return {1'b1, 4'h4};
            SEG_5:   return {1'b1, 4'h5};
            SEG_6:   return {1'b1, 4'h6};
            SEG_7:   return {1'b1, 4'h7};
            SEG_8:   return {1'b1, 4'h8};
            SEG_9:   return {1'b1, 4'h9};
            SEG_A:   return {1'b1, 4'hA};
            SEG_B:   return {1'b1, 4'hB};
            SEG_C:   return {1'b1, 4'hC};
            SEG_D:   return {1'b1, 4'hD};
            SEG_E:   return {1'b1, 4'hE};
            SEG_F:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

endpackage

// File: rtl/seg7_reader_enc.sv
// One HEX digit driver: shows the stored nibble when its slot is occupied,
// blank otherwise.
import seg7_pkg::*;

module seg7_enc (
    input  logic [3:0] nibble,
    input  logic       enable,
    output logic [6:0] pattern
);

    assign pattern = enable ? seg7_encode(nibble) : SEG_BLANK;

endmodule

// File: rtl/seg7_reader.sv
// DE10-Lite lab top: decodes a segment pattern on SW[6:0] back to a nibble,
// captures it on each KEY[0] press into a 4-deep history shown on HEX3..HEX0.
import seg7_pkg::*;

module seg7_reader (
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
);

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       capture;
    logic [4:0] dec;
    logic       dec_valid;
    logic [3:0] dec_nibble;
    logic       unused_sw7;

    // Slot 0 is the newest digit. Slots hold nibbles; an unoccupied slot
    // (index >= count) is rendered as blank by its encoder.
    logic [3:0] slot_reg [DEPTH];
    logic [2:0] count_reg;
    logic [3:0] last_reg;
    logic       err_reg;
    logic       ok_reg;

    logic [DEPTH-1:0] slot_en;
    logic [6:0]       hex_pat [DEPTH];

    assign clk        = KEY[0];
    assign rst_n      = KEY[1];
    assign clear      = SW[8];
    assign capture    = SW[9];
    assign unused_sw7 = SW[7];

    assign dec        = seg7_decode(SW[6:0]);
    assign dec_valid  = dec[4];
    assign dec_nibble = dec[3:0];

    // Capture/clear state machine; clear takes priority over capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_reg[i] <= 4'h0;
            count_reg <= 3'd0;
            last_reg  <= 4'h0;
            err_reg   <= 1'b0;
            ok_reg    <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) slot_reg[i] <= 4'h0;
            count_reg <= 3'd0;
            last_reg  <= 4'h0;
            err_reg   <= 1'b0;
            ok_reg    <= 1'b0;
        end else if (capture) begin
            if (dec_valid) begin
                for (int i = DEPTH - 1; i > 0; i--) slot_reg[i] <= slot_reg[i-1];
                slot_reg[0] <= dec_nibble;
                last_reg    <= dec_nibble;
                ok_reg      <= 1'b1;
                if (count_reg != 3'(DEPTH)) count_reg <= count_reg + 3'd1;
            end else begin
                ok_reg  <= 1'b0;
                err_reg <= 1'b1;
            end
        end
    end

    // One re-encoder per HEX digit, driven only from registered state.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hex
            assign slot_en[gi] = (count_reg > 3'(gi));
            seg7_enc u_enc (
                .nibble  (slot_reg[gi]),
                .enable  (slot_en[gi]),
                .pattern (hex_pat[gi])
            );
        end
    endgenerate

    assign HEX0 = hex_pat[0];
    assign HEX1 = hex_pat[1];
    assign HEX2 = hex_pat[2];
    assign HEX3 = hex_pat[3];

    assign LEDR = {ok_reg, err_reg, count_reg, 1'b0, last_reg};

endmodule
